// File: rtl/id_stage_p.sv
// Decode stage: IF/ID pipeline register, register file with optional
// write-to-read bypass, and immediate generation.
module id_stage_p #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushD,
  input  logic            StallD,
  input  logic            ValidF,
  input  logic [31:0]     InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCplus4F,
  input  logic            RegWriteW,
  input  logic [4:0]      rdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            ValidD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCplus4D,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ImmExtD,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [4:0]      RdD
);

  localparam int          AW  = $clog2(NREG);
  localparam logic [31:0] NOP = 32'h00000013;

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] rf_q [NREG];

  logic wr_en, rs1_ok, rs2_ok;

  // Flush wins over stall; both lose to reset in the register process.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (FlushD) begin
      valid_d = 1'b0;
      instr_d = NOP;
      pc_d    = '0;
      pc4_d   = '0;
    end else if (!StallD) begin
      valid_d = ValidF;
      instr_d = InstrF;
      pc_d    = PCF;
      pc4_d   = PCplus4F;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign wr_en = RegWriteW && (rdW != 5'd0) && (32'(rdW) < NREG);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[rdW[AW-1:0]] <= ResultW;
    end
  end

  assign Rs1D   = instr_q[19:15];
  assign Rs2D   = instr_q[24:20];
  assign RdD    = instr_q[11:7];
  assign rs1_ok = (Rs1D != 5'd0) && (32'(Rs1D) < NREG);
  assign rs2_ok = (Rs2D != 5'd0) && (32'(Rs2D) < NREG);

  // Out-of-range and x0 indices read as zero; bypass only for accepted writes.
  assign RD1D = !rs1_ok ? '0 :
                ((BYPASS != 0) && wr_en && (rdW == Rs1D)) ? ResultW : rf_q[Rs1D[AW-1:0]];
  assign RD2D = !rs2_ok ? '0 :
                ((BYPASS != 0) && wr_en && (rdW == Rs2D)) ? ResultW : rf_q[Rs2D[AW-1:0]];

  always_comb begin
    ImmExtD = '0;
    case (instr_q[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        ImmExtD = XLEN'($signed(instr_q[31:20]));
      7'b0100011:
        ImmExtD = XLEN'($signed({instr_q[31:25], instr_q[11:7]}));
      7'b1100011:
        ImmExtD = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0}));
      7'b0110111, 7'b0010111:
        ImmExtD = XLEN'($signed({instr_q[31:12], 12'b0}));
      7'b1101111:
        ImmExtD = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0}));
      default:
        ImmExtD = '0;
    endcase
  end

  assign ValidD   = valid_q;
  assign InstrD   = instr_q;
  assign PCD      = pc_q;
  assign PCplus4D = pc4_q;

endmodule
